// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

   // Oversampling ratio of s_tick against the bit rate.
   localparam int OVS         = 16;
   // Tick index at the middle of the start bit.
   localparam int MID_TICK    = 7;
   localparam int DEF_DBIT    = 8;
   localparam int DEF_SB_TICK = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver line inputs and received-word outputs (optional parity_err with UART_RX_PARITY_EN).
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take every rx_done_tick.
interface uart_rx_if
   import uart_pkg::*;
#(
   parameter int DBIT = DEF_DBIT
) ();

   logic            rx;
   logic            s_tick;
   logic [DBIT-1:0] dout;
   logic            rx_done_tick;
   logic            frame_err;
`ifdef UART_RX_PARITY_EN
   logic            parity_err;

   modport master (input rx, s_tick, output dout, rx_done_tick, frame_err, parity_err);
   modport slave  (output rx, s_tick, input dout, rx_done_tick, frame_err, parity_err);
`else
   modport master (input rx, s_tick, output dout, rx_done_tick, frame_err);
   modport slave  (output rx, s_tick, input dout, rx_done_tick, frame_err);
`endif

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, reset to RST_VAL.
// Latency: 2 clk.
// Backpressure: none.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Capture the async input then re-register to settle metastability.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (16x s_tick); UART_RX_PARITY_EN adds an even-parity bit and parity_err.
// Latency: rx -> rx_s 2 clk; rx_done_tick/dout/frame_err update together at the stop-bit sample.
// Backpressure: none; never stalls, consumer decides what to do with each word.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = DEF_DBIT,
   parameter int SB_TICK = DEF_SB_TICK
) (
   input  logic      clk,
   input  logic      reset,
   uart_rx_if.master bus
);

   // Tick counter must reach SB_TICK-1 for 1.5/2 stop bits, so widen it past 4 bits when needed.
   localparam int SW = (SB_TICK > OVS) ? $clog2(SB_TICK) : $clog2(OVS);
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   logic            rx_s;
   logic [1:0]      sync_fill_q;
   state_t          state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            armed_q, armed_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic            par_q, par_d;
   logic            perr_q, perr_d;
`endif

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.rx),
      .q     (rx_s)
   );

   // The synchroniser shows its reset value (1) for two clocks after reset; this marks
   // when rx_s reflects the real line so a line held low is not mistaken for idle-high.
   always_ff @(posedge clk) begin
      if (reset) sync_fill_q <= 2'b00;
      else       sync_fill_q <= {sync_fill_q[0], 1'b1};
   end

   // Next-state and datapath: counters only move on s_tick, arming/start detect run every clk.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      dout_d  = dout_q;
      armed_d = armed_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = perr_q;
`endif
      case (state_q)
         IDLE: begin
            if (!armed_q) begin
               if (rx_s && sync_fill_q[1]) armed_d = 1'b1;
            end else if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (bus.s_tick) begin
               if (s_q == SW'(MID_TICK)) begin
                  s_d = '0;
                  if (!rx_s) begin
                     state_d = DATA;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (bus.s_tick) begin
               if (s_q == SW'(OVS - 1)) begin
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  s_d = '0;
                  if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (bus.s_tick) begin
               if (s_q == SW'(OVS - 1)) begin
                  par_d   = rx_s;
                  s_d     = '0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
`else
            state_d = IDLE;
`endif
         end
         STOP: begin
            if (bus.s_tick) begin
               if (s_q == SW'(SB_TICK - 1)) begin
                  dout_d  = b_q;
                  ferr_d  = ~rx_s;
                  done_d  = 1'b1;
                  s_d     = '0;
                  state_d = IDLE;
                  // A low stop (break) leaves us disarmed until the line returns high.
                  armed_d = rx_s;
`ifdef UART_RX_PARITY_EN
                  perr_d  = ^{b_q, par_q};
`endif
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial frame and clears outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         armed_q <= 1'b0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         armed_q <= armed_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign bus.dout         = dout_q;
   assign bus.rx_done_tick = done_q;
   assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, expected words queued at send time.
// A negedge monitor pops and compares on every rx_done_tick.
// Covers UART_RX_PARITY_EN cases when that macro is defined.
`timescale 1ns/1ps
module tb_uart_rx;
   import uart_pkg::*;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   uart_rx_if #(.DBIT(DBIT)) bus ();

   uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests    = 0;
   int   fails    = 0;
   int   n_done   = 0;
   int   tick_div = 1;
   int   div_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // s_tick generator: one pulse every tick_div clocks, changed on negedge.
   always @(negedge clk) begin
      if (div_cnt >= tick_div - 1) begin
         div_cnt    = 0;
         bus.s_tick = 1'b1;
      end else begin
         div_cnt    = div_cnt + 1;
         bus.s_tick = 1'b0;
      end
   end

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.rx_done_tick === 1'b1) begin
         n_done++;
         check("done_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("dout", 32'(bus.dout), 32'(mon_e.d));
            check("frame_err", 32'(bus.frame_err), 32'(mon_e.fe));
`ifdef UART_RX_PARITY_EN
            check("parity_err", 32'(bus.parity_err), 32'(mon_e.pe));
`endif
         end
      end
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (bus.s_tick !== 1'b1);
      end
   endtask

   task automatic drive(input logic b, input int n);
      @(negedge clk);
      bus.rx = b;
      wait_ticks(n);
   endtask

   task automatic expect_word(input logic [7:0] d, input logic fe, input logic pe);
      exp_t e;
      e.d  = d;
      e.fe = fe;
      e.pe = pe;
      sb.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      drive(1'b0, 16);
      for (int i = 0; i < DBIT; i++) drive(d[i], 16);
`ifdef UART_RX_PARITY_EN
      drive(^d, 16);
`endif
      drive(stop_b, SB_TICK);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_par_frame(input logic [7:0] d, input logic par_b);
      drive(1'b0, 16);
      for (int i = 0; i < DBIT; i++) drive(d[i], 16);
      drive(par_b, 16);
      drive(1'b1, SB_TICK);
   endtask
`endif

   initial begin
      logic [7:0] partial;
      bus.rx     = 1'b1;
      bus.s_tick = 1'b0;
      reset      = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      check("rst_dout", 32'(bus.dout), 32'h0);
      check("rst_done", 32'(bus.rx_done_tick), 32'h0);
      check("rst_ferr", 32'(bus.frame_err), 32'h0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      drive(1'b1, 20);

      // Single frame, tick every clock.
      tick_div = 1;
      expect_word(8'h0F, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b1);
      drive(1'b1, 20);
      check("t1_count", 32'(n_done), 32'd1);
      check("t1_hold", 32'(bus.dout), 32'h0F);

      // Back-to-back frames, tick every 4 clocks, no idle gap.
      tick_div = 4;
      expect_word(8'h0F, 1'b0, 1'b0);
      expect_word(8'h0E, 1'b0, 1'b0);
      expect_word(8'h0C, 1'b0, 1'b0);
      expect_word(8'h08, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b1);
      send_frame(8'h0E, 1'b1);
      send_frame(8'h0C, 1'b1);
      send_frame(8'h08, 1'b1);
      drive(1'b1, 20);
      check("t2_count", 32'(n_done), 32'd5);

      // Short low glitch rejected at mid start bit.
      drive(1'b0, 4);
      drive(1'b1, 30);
      check("glitch_count", 32'(n_done), 32'd5);
      check("glitch_idle", 32'(dut.state_q), 32'(IDLE));
      expect_word(8'h6C, 1'b0, 1'b0);
      send_frame(8'h6C, 1'b1);
      drive(1'b1, 20);
      check("t3_count", 32'(n_done), 32'd6);

      // Low stop bit then break: one flagged frame, nothing more while low.
      expect_word(8'hA5, 1'b1, 1'b0);
      send_frame(8'hA5, 1'b0);
      drive(1'b0, 400);
      check("break_count", 32'(n_done), 32'd7);
      check("break_dout", 32'(bus.dout), 32'hA5);
      drive(1'b1, 20);

      // Reset during data bit 3 of 0x3C with the line low at release.
      partial = 8'h3C;
      drive(1'b0, 16);
      for (int i = 0; i < 3; i++) drive(partial[i], 16);
      drive(partial[3], 8);
      @(negedge clk);
      reset  = 1'b1;
      bus.rx = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 200);
      check("rst_mid_count", 32'(n_done), 32'd7);
      check("rst_mid_dout", 32'(bus.dout), 32'h0);
      check("rst_mid_armed", 32'(dut.armed_q), 32'h0);
      drive(1'b1, 20);
      expect_word(8'h55, 1'b0, 1'b0);
      send_frame(8'h55, 1'b1);
      drive(1'b1, 20);
      check("t5_count", 32'(n_done), 32'd8);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: parity bit 1 makes it even, 0 is an error.
      expect_word(8'h07, 1'b0, 1'b0);
      send_par_frame(8'h07, 1'b1);
      expect_word(8'h07, 1'b0, 1'b1);
      send_par_frame(8'h07, 1'b0);
      drive(1'b1, 20);
      check("par_count", 32'(n_done), 32'd10);
`endif

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver: deserialises the asynchronous `rx` line into parallel bytes.
- Issues a one-cycle `rx_done_tick` per received frame.
- Sits directly upstream of the receive FIFO: `rx_done_tick` drives the FIFO `wr`, `dout` drives `w_data`.
- Timing comes from an external baud tick `s_tick` at 16x the bit rate.

Parameters:
- DBIT, 8, data bits per frame, LSB first; legal range 5..9.
- SB_TICK, 16, s_ticks in the stop interval: 16 = 1 stop bit, 24 = 1.5, 32 = 2.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high; one clock; no other clock domains.
- rx, input, 1, asynchronous serial line; idles high.
- s_tick, input, 1, one-clk pulse at 16x the baud rate.
- dout, output, DBIT, last received data word.
- rx_done_tick, output, 1, one-clk pulse when `dout` is updated.
- frame_err, output, 1, valid with `rx_done_tick`: 1 = stop bit sampled low.

Behaviour:
- Input synchroniser:
  - `rx` passes through a 2-flop synchroniser; both flops reset to 1.
  - All decisions use the synchronised `rx_s` (+2 clk input latency).
- Reset values:
  - state = IDLE; s counter, n counter and shift register = 0.
  - `dout` = 0, `rx_done_tick` = 0, `frame_err` = 0.
  - armed flag = 0.
- Arming:
  - In IDLE, the armed flag sets once `rx_s` is seen high.
  - A start is recognised only when armed and `rx_s` = 0, so a line held low through reset release is never taken as a start bit.
- State machine (s = 4-bit tick counter, n = bit counter, clog2(DBIT) bits):
  - IDLE: armed and `rx_s` = 0 -> START, s = 0.
  - START, on s_tick:
    - s = 7 (mid start bit) and `rx_s` = 0 -> DATA, s = 0, n = 0.
    - s = 7 and `rx_s` = 1 -> glitch: return to IDLE, no output.
    - Otherwise s++.
  - DATA, on s_tick:
    - s = 15 -> sample `rx_s` into the shift register (shift right, new bit into MSB), s = 0.
    - Then if n = DBIT-1 -> STOP, else n++.
    - Otherwise s++.
  - STOP, on s_tick:
    - s = SB_TICK-1 -> sample `rx_s`; `dout` <= shift register; `frame_err` <= ~`rx_s`; `rx_done_tick` = 1 for one clk; -> IDLE with armed = `rx_s`.
    - Otherwise s++.
- Counters advance only on cycles with s_tick = 1; between ticks all state holds.
- Output timing:
  - `dout` and `frame_err` are registered and hold until the next `rx_done_tick`.
  - `rx_done_tick` fires even when `frame_err` = 1; the consumer decides whether to drop the byte.
- No backpressure: the FIFO-full policy belongs to the consumer. The receiver never stalls.
- Back-to-back frames:
  - After a good stop bit the receiver returns to IDLE armed.
  - The next falling edge is accepted with no idle gap beyond the stop interval.
- Reset mid-frame:
  - Return to IDLE disarmed; no `rx_done_tick`; the partial byte is discarded.
  - `dout` returns to 0.
- Break (rx held low): one frame with data 0 and `frame_err` = 1, then no further frames until `rx_s` returns high.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP; the parity bit is sampled at s = 15.
  - An extra output `parity_err` (1 bit, reset 0) is valid with `rx_done_tick`.
  - `parity_err` = 1 when the XOR of the data bits and the parity bit is not 0 (even parity).
- Undefined: no PARITY state and no `parity_err` port; frame = start + DBIT + stop.

Decomposition:
- Package uart_pkg:
  - State enum {IDLE, START, DATA, PARITY, STOP}.
  - OVS = 16, MID_TICK = 7, default DBIT/SB_TICK.
- Sub-module sync_2ff: the 2-flop synchroniser, with reset value as a parameter.
- The FSM and datapath stay in uart_rx.

Test Plan:
- Frame 0x0F, s_tick every clk, 1 stop bit -> exactly one `rx_done_tick`, `dout` = 8'h0F, `frame_err` = 0; `dout` holds 8'h0F afterwards.
- Back-to-back frames 0x0F, 0x0E, 0x0C, 0x08 with no idle gap, s_tick every 4 clk -> four `rx_done_tick` pulses in order with matching `dout`, all `frame_err` = 0.
- rx low for 4 s_ticks then high -> no `rx_done_tick`, FSM back in IDLE. A following 0x6C frame is received correctly.
- Frame 0xA5 with stop bit driven 0 -> `rx_done_tick` with `dout` = 8'hA5 and `frame_err` = 1. With rx then held low, no second frame until rx goes high.
- reset asserted during data bit 3 of a 0x3C frame, rx held low at release -> no `rx_done_tick` and `dout` = 0. After rx goes high, a following 0x55 frame is received correctly.
- UART_RX_PARITY_EN: 0x07 with parity bit 1 -> `parity_err` = 0. Same frame with parity bit 0 -> `parity_err` = 1, `dout` = 8'h07.
